// File: rtl/decoder_pkg.sv
// Shared definitions for the select/strobe decoder family.
//   MODE_DIRECT / MODE_SCAN : encoding of the 'mode' input
//   state_t                 : FSM states, one per mode
//   clog2()                 : ceiling log2 for parameter-derived widths
//   onehot()                : one-hot decode of up to 6 select bits
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // Ceiling log2; clog2(1) = 0, so callers clamp to a minimum of 1 bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One-hot of 'sel' in a 64-bit word; selects at or beyond 'width'
    // give all-zeros so callers can truncate safely.
    function automatic logic [63:0] onehot(input logic [5:0] sel, input int width);
        logic [63:0] result;
        result = '0;
        if (int'(sel) < width) begin
            result = 64'd1 << sel;
        end
        return result;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divide-by-PRESCALE step counter for the scan decoder.
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   clear  : force count to 0 (wins over enable)
//   enable : count this cycle
//   tc     : terminal count, high while enabled at count PRESCALE-1;
//            the count wraps to 0 on that same edge
module scan_prescaler #(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign tc = enable && (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = tc ? '0 : count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/decoder_nx2n_scan.sv
// Registered N-to-2^N decoder with direct and auto-scan select sources.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   en      : enable; low forces y inactive and freezes select/prescaler
//   mode    : 0 = decode sel_in, 1 = auto-scan
//   sel_in  : direct select, or scan start value when load = 1
//   load    : scan mode only, load sel_in into the scan select
//   y       : one-hot (one-cold when ACTIVE_LOW) decode of sel_out
//   sel_out : current select
//   valid   : registered en
//   strobe  : pulse on each scan advance or load
//   wrap    : pulse on the scan step from all-ones back to 0
module decoder_nx2n_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int PRESCALE   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  load,
    output logic [(1<<SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      sel_out,
    output logic                  valid,
    output logic                  strobe,
    output logic                  wrap
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int PRE_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    state_t state_reg, state_next;

    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [OUT_W-1:0] y_reg, y_next;
    logic             valid_reg, strobe_reg, strobe_next, wrap_reg, wrap_next;
    logic             pre_clear, pre_enable, pre_tc;
    logic             mode_change;

    scan_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (PRE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (pre_clear),
        .enable (pre_enable),
        .tc     (pre_tc)
    );

    // The state tracks the last mode seen while enabled, so a mode flip
    // made while disabled is still treated as a switch on re-enable.
    always_comb begin
        state_next = state_reg;
        if (en) begin
            state_next = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        end
    end

    assign mode_change = (mode == MODE_SCAN) != (state_reg == ST_SCAN);

    always_comb begin
        sel_next    = sel_reg;
        strobe_next = 1'b0;
        wrap_next   = 1'b0;
        pre_clear   = 1'b0;
        pre_enable  = 1'b0;
        if (en) begin
            if (mode == MODE_DIRECT) begin
                sel_next  = sel_in;
                pre_clear = 1'b1;
            end else if (load) begin
                sel_next    = sel_in;
                pre_clear   = 1'b1;
                strobe_next = 1'b1;
            end else if (mode_change) begin
                // Switch edge: restart the cadence, keep the select.
                pre_clear = 1'b1;
            end else begin
                pre_enable = 1'b1;
                if (pre_tc) begin
                    sel_next    = sel_reg + SEL_W'(1);
                    strobe_next = 1'b1;
                    wrap_next   = (sel_reg == {SEL_W{1'b1}});
                end
            end
        end
    end

    // y is decoded from sel_next so y and sel_out always agree once registered.
    always_comb begin
        y_next = INACTIVE;
        if (en) begin
            y_next = OUT_W'(onehot(6'(sel_next), OUT_W)) ^ INACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_DIRECT;
            sel_reg    <= '0;
            y_reg      <= INACTIVE;
            valid_reg  <= 1'b0;
            strobe_reg <= 1'b0;
            wrap_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            y_reg      <= y_next;
            valid_reg  <= en;
            strobe_reg <= strobe_next;
            wrap_reg   <= wrap_next;
        end
    end

    assign y       = y_reg;
    assign sel_out = sel_reg;
    assign valid   = valid_reg;
    assign strobe  = strobe_reg;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
module tb_decoder_nx2n_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: SEL_W=2, PRESCALE=4, ACTIVE_LOW=0
    logic       rst_a, en_a, mode_a, load_a;
    logic [1:0] sel_in_a;
    logic [3:0] y_a;
    logic [1:0] sel_out_a;
    logic       valid_a, strobe_a, wrap_a;

    // DUT B: SEL_W=3, PRESCALE=1, ACTIVE_LOW=1
    logic       rst_b, en_b, mode_b, load_b;
    logic [2:0] sel_in_b;
    logic [7:0] y_b;
    logic [2:0] sel_out_b;
    logic       valid_b, strobe_b, wrap_b;

    int errors = 0;
    int checks = 0;

    decoder_nx2n_scan #(.SEL_W(2), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .sel_in(sel_in_a),
        .load(load_a), .y(y_a), .sel_out(sel_out_a), .valid(valid_a),
        .strobe(strobe_a), .wrap(wrap_a)
    );

    decoder_nx2n_scan #(.SEL_W(3), .PRESCALE(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .sel_in(sel_in_b),
        .load(load_b), .y(y_b), .sel_out(sel_out_b), .valid(valid_b),
        .strobe(strobe_b), .wrap(wrap_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] ey, input logic [1:0] es,
                         input logic ev, input logic est, input logic ew);
        chk({tag, ".y"},      64'(y_a),       64'(ey));
        chk({tag, ".sel"},    64'(sel_out_a), 64'(es));
        chk({tag, ".valid"},  64'(valid_a),   64'(ev));
        chk({tag, ".strobe"}, 64'(strobe_a),  64'(est));
        chk({tag, ".wrap"},   64'(wrap_a),    64'(ew));
        $display("A %-10s y=%b sel=%0d valid=%b strobe=%b wrap=%b", tag, y_a, sel_out_a, valid_a, strobe_a, wrap_a);
    endtask

    initial begin
        logic [3:0] oh4;
        logic [7:0] oh8;
        logic [1:0] s2;
        logic [2:0] s3;

        rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; load_b = 1'b0; sel_in_b = 3'd0;

        // Reset with random inputs for two cycles
        for (int i = 0; i < 2; i++) begin
            rst_a = 1'b1; en_a = 1'($urandom); mode_a = 1'($urandom);
            load_a = 1'($urandom); sel_in_a = 2'($urandom);
            tick();
            chk_a("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        end

        // Direct sweep
        rst_a = 1'b0; en_a = 1'b1; mode_a = 1'b0; load_a = 1'b0;
        sel_in_a = 2'd0; tick(); chk_a("direct0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        sel_in_a = 2'd1; tick(); chk_a("direct1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        sel_in_a = 2'd2; tick(); chk_a("direct2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        sel_in_a = 2'd3; tick(); chk_a("direct3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        sel_in_a = 2'd0; tick(); chk_a("direct0b", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

        // Switch to scan: no strobe on the switch edge, sel carries over
        mode_a = 1'b1; sel_in_a = 2'd3;
        tick(); chk_a("switch", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

        // Scan: advance every 4th edge, wrap on 3->0
        for (int k = 1; k <= 16; k++) begin
            s2 = 2'((k / 4) % 4);
            oh4 = 4'b0001 << s2;
            tick();
            chk_a("scan", oh4, s2, 1'b1, (k % 4) == 0, k == 16);
        end

        // Bring prescaler to 3, then load beats the pending advance
        for (int k = 0; k < 3; k++) begin
            tick(); chk_a("prep", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        end
        load_a = 1'b1; sel_in_a = 2'd2;
        tick(); chk_a("load", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
        load_a = 1'b0; sel_in_a = 2'd0;
        for (int k = 0; k < 3; k++) begin
            tick(); chk_a("postload", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        end
        tick(); chk_a("adv3", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);

        // Two counts into the period, then freeze for 5 cycles (load ignored)
        tick(); chk_a("cnt1", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        tick(); chk_a("cnt2", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        en_a = 1'b0; load_a = 1'b1; sel_in_a = 2'd1;
        for (int k = 0; k < 5; k++) begin
            tick(); chk_a("frozen", 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0);
        end
        en_a = 1'b1; load_a = 1'b0;
        tick(); chk_a("resume", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        tick(); chk_a("resumewrap", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);

        // Sync reset mid-scan
        tick(); chk_a("midscan", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        rst_a = 1'b1;
        tick(); chk_a("midrst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0; en_a = 1'b0;

        // DUT B: SEL_W=3, PRESCALE=1, active-low
        tick();
        chk("b.reset.y", 64'(y_b), 64'(8'hFF));
        chk("b.reset.valid", 64'(valid_b), 64'd0);
        $display("B reset      y=%b sel=%0d valid=%b", y_b, sel_out_b, valid_b);
        rst_b = 1'b0; en_b = 1'b1; mode_b = 1'b1;
        tick();
        chk("b.switch.y", 64'(y_b), 64'(8'hFE));
        chk("b.switch.strobe", 64'(strobe_b), 64'd0);
        $display("B switch     y=%b sel=%0d strobe=%b", y_b, sel_out_b, strobe_b);
        for (int k = 1; k <= 16; k++) begin
            s3 = 3'(k % 8);
            oh8 = ~(8'b0000_0001 << s3);
            tick();
            chk("b.scan.y", 64'(y_b), 64'(oh8));
            chk("b.scan.sel", 64'(sel_out_b), 64'(s3));
            chk("b.scan.strobe", 64'(strobe_b), 64'd1);
            chk("b.scan.wrap", 64'(wrap_b), 64'((k % 8) == 0));
            $display("B scan       y=%b sel=%0d strobe=%b wrap=%b", y_b, sel_out_b, strobe_b, wrap_b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
